// File: rtl/ringosc_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package ringosc_pkg;

  localparam int DEF_CHAIN_LENGTH = 1001;
  localparam int DEF_NUM_TAPS     = 8;
  localparam int DEF_DIV_BITS     = 4;
  localparam int DEF_GATE_BITS    = 10;
  localparam int DEF_COUNT_W      = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ARM   = 2'd1;
  localparam state_t ST_COUNT = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Stage output observed by tap k; taps are spread evenly and the last tap is the chain end.
  function automatic int tap_index(input int k, input int chain_length, input int num_taps);
    return ((k + 1) * chain_length / num_taps) - 1;
  endfunction

endpackage

// File: rtl/ring_chain.sv
// Inverter chain with gated head, closed/open mode select and a tap multiplexer.
module ring_chain
  import ringosc_pkg::*;
#(
  parameter  int CHAIN_LENGTH = DEF_CHAIN_LENGTH,
  parameter  int NUM_TAPS     = DEF_NUM_TAPS,
  localparam int SEL_W        = $clog2(NUM_TAPS)
) (
  input  logic             ring_en_i,
  input  logic             open_mode_i,
  input  logic             chain_in_i,
  input  logic [SEL_W-1:0] tap_sel_i,
  output logic             tap_o
);

  logic head;
  logic stage [CHAIN_LENGTH];
  logic taps  [NUM_TAPS];

  assign head = ring_en_i & (open_mode_i ? chain_in_i : stage[CHAIN_LENGTH-1]);

  for (genvar i = 0; i < CHAIN_LENGTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      ringosc_inv_cell u_inv (.a_i(head), .y_o(stage[i]));
    end else begin : g_next
      ringosc_inv_cell u_inv (.a_i(stage[i-1]), .y_o(stage[i]));
    end
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    localparam int IDX = tap_index(k, CHAIN_LENGTH, NUM_TAPS);
    assign taps[k] = stage[IDX];
  end

  assign tap_o = taps[tap_sel_i];

endmodule

// File: rtl/ringosc_inv_cell.sv
// Single inverter stage of the ring; kept as its own cell so layout can hand-place it.
module ringosc_inv_cell (
  input  logic a_i,
  output logic y_o
);

  assign y_o = ~a_i;

endmodule

// File: rtl/ringosc_freq_meter.sv
// Ring-oscillator frequency meter: ring-domain prescaler, synchroniser and a gated edge counter.
module ringosc_freq_meter
  import ringosc_pkg::*;
#(
  parameter  int CHAIN_LENGTH = DEF_CHAIN_LENGTH,
  parameter  int NUM_TAPS     = DEF_NUM_TAPS,
  parameter  int DIV_BITS     = DEF_DIV_BITS,
  parameter  int GATE_BITS    = DEF_GATE_BITS,
  parameter  int COUNT_W      = DEF_COUNT_W,
  localparam int SEL_W        = $clog2(NUM_TAPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ring_en,
  input  logic               open_mode,
  input  logic               chain_in,
  input  logic [SEL_W-1:0]   tap_sel,
  input  logic               start,
  output logic               busy,
  output logic               result_valid,
  output logic [COUNT_W-1:0] result,
  output logic               overflow,
  output logic               tap_out
);

  logic tap_raw;
  logic div_sig;

  ring_chain #(
    .CHAIN_LENGTH(CHAIN_LENGTH),
    .NUM_TAPS    (NUM_TAPS)
  ) u_chain (
    .ring_en_i  (ring_en),
    .open_mode_i(open_mode),
    .chain_in_i (chain_in),
    .tap_sel_i  (tap_sel),
    .tap_o      (tap_raw)
  );

  assign tap_out = tap_raw;

  // Ripple prescaler: each stage toggles on the falling edge of the one before it.
  if (DIV_BITS == 0) begin : g_nodiv
    assign div_sig = tap_raw;
  end else begin : g_div
    for (genvar i = 0; i < DIV_BITS; i++) begin : g_bit
      logic bit_clk;
      logic toggle_q;
      if (i == 0) begin : g_src
        assign bit_clk = tap_raw;
      end else begin : g_src
        assign bit_clk = ~g_bit[i-1].toggle_q;
      end
      always_ff @(posedge bit_clk or negedge rst_n) begin
        if (!rst_n) toggle_q <= 1'b0;
        else        toggle_q <= ~toggle_q;
      end
    end
    assign div_sig = g_bit[DIV_BITS-1].toggle_q;
  end

  logic [1:0]         sync_q;
  logic               hist_q;
  logic               rise;
  state_t             state_q, state_d;
  logic [GATE_BITS-1:0] gate_q, gate_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] result_q, result_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;

  // History follows the synchronised value every cycle, so the value captured
  // during ARM is the reference for the first COUNT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its source.
      sync_q <= {sync_q[0], div_sig};
      hist_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~hist_q;

  always_comb begin
    // NOTE: every output gets a default first, otherwise unassigned paths infer latches.
    state_d  = state_q;
    gate_d   = gate_q;
    count_d  = count_q;
    result_d = result_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARM;
          valid_d = 1'b0;
          ovf_d   = 1'b0;
          count_d = '0;
        end
      end
      ST_ARM: begin
        gate_d  = '0;
        state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (rise) begin
          if (count_q == '1) ovf_d   = 1'b1;
          else               count_d = count_q + COUNT_W'(1);
        end
        gate_d = gate_q + GATE_BITS'(1);
        if (gate_q == '1) state_d = ST_DONE;
      end
      ST_DONE: begin
        result_d = count_q;
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gate_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gate_q   <= gate_d;
      count_q  <= count_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign result_valid = valid_q;
  assign result       = result_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Directed bench for ringosc_freq_meter: vector table plus hand-written timing/reset sequences.
module tb_ringosc_freq_meter;

  logic        clk;
  logic        rst_n;
  logic        ring_en, open_mode, chain_in, start;
  logic [2:0]  tap_sel;
  logic        busy, result_valid, overflow, tap_out;
  logic [15:0] result;

  logic        chain_in_s, start_s;
  logic [0:0]  tap_sel_s;
  logic        busy_s, valid_s, ovf_s, tap_out_s;
  logic [2:0]  result_s;

  int   half_a, half_s;
  logic const_a;
  int   n_checks, n_errors;

  ringosc_freq_meter #(
    .CHAIN_LENGTH(33), .NUM_TAPS(8), .DIV_BITS(2), .GATE_BITS(10), .COUNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ring_en(ring_en), .open_mode(open_mode),
    .chain_in(chain_in), .tap_sel(tap_sel), .start(start), .busy(busy),
    .result_valid(result_valid), .result(result), .overflow(overflow), .tap_out(tap_out)
  );

  ringosc_freq_meter #(
    .CHAIN_LENGTH(5), .NUM_TAPS(2), .DIV_BITS(0), .GATE_BITS(6), .COUNT_W(3)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .ring_en(1'b1), .open_mode(1'b1),
    .chain_in(chain_in_s), .tap_sel(tap_sel_s), .start(start_s), .busy(busy_s),
    .result_valid(valid_s), .result(result_s), .overflow(ovf_s), .tap_out(tap_out_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Square-wave heads, changed on the falling clock edge; half = 0 means hold constant.
  initial begin
    int ph;
    ph = 0;
    chain_in = 1'b0;
    forever begin
      @(negedge clk);
      if (half_a == 0) begin
        chain_in = const_a;
        ph = 0;
      end else if (ph + 1 >= half_a) begin
        ph = 0;
        chain_in = ~chain_in;
      end else begin
        ph++;
      end
    end
  end

  initial begin
    int ph;
    ph = 0;
    chain_in_s = 1'b0;
    forever begin
      @(negedge clk);
      if (half_s == 0) begin
        chain_in_s = 1'b0;
      end else if (ph + 1 >= half_s) begin
        ph = 0;
        chain_in_s = ~chain_in_s;
      end else begin
        ph++;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Count cycles from the start-sampling edge until result_valid is seen.
  task automatic measure(input bit repulse, output int lat, output bit busy_ok, output bit busy_at_done);
    lat = 0;
    busy_ok = 1'b1;
    busy_at_done = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 1200; c++) begin
      @(negedge clk);
      start = repulse && (c == 5 || c == 500);
      if (result_valid) begin
        lat = c;
        busy_at_done = busy;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int c = 1; c <= 1200; c++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  typedef struct {
    string      name;
    int         half;
    logic [2:0] sel;
    logic       en;
    int         exp_result;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat;
    bit bok, bdone, seen;

    vecs[0] = '{"p16_tap0",  8, 3'd0, 1'b1, 16};
    vecs[1] = '{"p16_tap7",  8, 3'd7, 1'b1, 16};
    vecs[2] = '{"const0",    0, 3'd3, 1'b1, 0};
    vecs[3] = '{"p8_tap2",   4, 3'd2, 1'b1, 32};
    vecs[4] = '{"p32_tap5", 16, 3'd5, 1'b1, 8};
    vecs[5] = '{"p4_tap1",   2, 3'd1, 1'b1, 64};
    vecs[6] = '{"ring_off",  8, 3'd0, 1'b0, 0};
    vecs[7] = '{"p2_tap6",   1, 3'd6, 1'b1, 128};

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    ring_en = 1'b1;
    open_mode = 1'b1;
    tap_sel = 3'd0;
    start = 1'b0;
    half_a = 8;
    const_a = 1'b0;
    start_s = 1'b0;
    tap_sel_s = 1'b0;
    half_s = 2;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy_s", busy_s, 0);
    check("rst_valid_s", valid_s, 0);
    check("rst_result_s", result_s, 0);
    rst_n = 1'b1;

    // Saturation: 16 tap edges into a 3-bit counter over a 64-cycle window.
    repeat (20) @(negedge clk);
    start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (valid_s) begin
        lat = c;
        break;
      end
    end
    check("sat_latency", lat, 66);
    check("sat_result", result_s, 7);
    check("sat_overflow", ovf_s, 1);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      half_a  = vecs[i].half;
      tap_sel = vecs[i].sel;
      ring_en = vecs[i].en;
      repeat (300) @(negedge clk);
      measure(1'b0, lat, bok, bdone);
      check({vecs[i].name, "_latency"}, lat, 1026);
      check({vecs[i].name, "_result"}, result, vecs[i].exp_result);
      check({vecs[i].name, "_overflow"}, overflow, 0);
      check({vecs[i].name, "_busy_hold"}, bok, 1);
      check({vecs[i].name, "_busy_fall"}, bdone, 0);
    end

    @(negedge clk);
    half_a = 8; tap_sel = 3'd0; ring_en = 1'b1;
    repeat (300) @(negedge clk);

    // Restart requests inside the window are ignored.
    measure(1'b1, lat, bok, bdone);
    check("repulse_latency", lat, 1026);
    check("repulse_busy_hold", bok, 1);
    check("repulse_result", result, 16);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("repulse_no_restart", seen, 0);

    // Start sampled on the edge where result_valid rises is dropped.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (1025) @(negedge clk);
    check("done_busy", busy, 1);
    check("done_valid_low", result_valid, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_valid_rise", result_valid, 1);
    check("done_busy_fall", busy, 0);
    @(negedge clk);
    check("start_in_done_ignored", busy, 0);

    // Start held into the following IDLE cycle is accepted there.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (1025) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    check("start_after_done_accepted", busy, 1);
    check("start_after_done_valid_clr", result_valid, 0);
    wait_valid(lat);
    check("start_after_done_latency", lat, 1026);
    check("start_after_done_result", result, 16);

    // Tap polarity with static heads, open chain then closed ring.
    @(negedge clk);
    half_a = 0; const_a = 1'b1; tap_sel = 3'd0;
    @(negedge clk); #2;
    check("open_hi_tap0", tap_out, 1);
    tap_sel = 3'd7; #1;
    check("open_hi_tap7", tap_out, 0);
    ring_en = 1'b0; #1;
    check("open_off_tap7", tap_out, 1);
    open_mode = 1'b0; #1;
    check("closed_off_tap7", tap_out, 1);
    tap_sel = 3'd0; #1;
    check("closed_off_tap0", tap_out, 0);
    open_mode = 1'b1; #1;
    ring_en = 1'b1; half_a = 8; const_a = 1'b0;
    repeat (300) @(negedge clk);

    // Reset in the middle of a window.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (300) @(negedge clk);
    rst_n = 1'b0; #1;
    check("abort_busy", busy, 0);
    check("abort_valid", result_valid, 0);
    check("abort_result", result, 0);
    check("abort_overflow", overflow, 0);
    check("abort_result_s", result_s, 0);
    check("abort_overflow_s", ovf_s, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (1100) begin
      @(negedge clk);
      if (busy || result_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ringosc_freq_meter.md
RINGOSC_FREQ_METER -- requirements
Module: ringosc_freq_meter

Interface
REQ-001 Parameter CHAIN_LENGTH, default 1001, inverter stages in chain; SHALL be odd and >= 3.
REQ-002 Parameter NUM_TAPS, default 8, number of selectable tap points; SHALL be a power of two >= 2.
REQ-003 Parameter DIV_BITS, default 4, ring-domain prescaler width; divided output = tap frequency / 2^DIV_BITS.
REQ-004 Parameter GATE_BITS, default 10, gate window = GATE_CYCLES = 2^GATE_BITS clk cycles.
REQ-005 Parameter COUNT_W, default 16, result counter width.
REQ-006 clk  input  1  system clock, sole clock of the measurement logic.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 ring_en  input  1  1 = chain head fed (oscillation allowed); 0 = chain head forced 0.
REQ-009 open_mode  input  1  0 = closed ring (last stage feeds head); 1 = open chain, head driven by chain_in.
REQ-010 chain_in  input  1  external head stimulus, used only when open_mode = 1.
REQ-011 tap_sel  input  log2(NUM_TAPS)  selects tap k at stage output index ((k+1)*CHAIN_LENGTH/NUM_TAPS)-1.
REQ-012 start  input  1  single-cycle measurement request.
REQ-013 busy  output  1  measurement in progress.
REQ-014 result_valid  output  1  result holds a completed measurement.
REQ-015 result  output  COUNT_W  divided-tap rising edges counted in last gate window.
REQ-016 overflow  output  1  count saturated in last window.
REQ-017 tap_out  output  1  raw selected tap, combinational, unsynchronised, for pad observation.

Function
REQ-018 Chain head = ring_en AND (open_mode ? chain_in : last stage output); stages are the team's existing inverter cell.
REQ-019 Prescaler SHALL be a DIV_BITS-bit ripple toggle divider clocked by the selected tap, async-cleared by rst_n; its MSB is the divided signal.
REQ-020 Divided signal SHALL pass a 2-flop synchroniser into clk, then a third flop for rising-edge detection.
REQ-021 FSM states IDLE, ARM, COUNT, DONE; encoding in the package.
REQ-022 IDLE: start = 1 -> ARM; clears result_valid, overflow and the counter.
REQ-023 ARM: one cycle, loads edge-detect history with the current synchronised value (no edge counted), loads gate counter with 0, -> COUNT.
REQ-024 COUNT: exactly GATE_CYCLES cycles; each detected rising edge increments counter; at gate count GATE_CYCLES-1 -> DONE.
REQ-025 Counter SHALL saturate at 2^COUNT_W-1 and set overflow; no wrap-around.
REQ-026 DONE: one cycle, copies counter to result, sets result_valid, -> IDLE.
REQ-027 busy = 1 in ARM, COUNT, DONE; result_valid rises GATE_CYCLES+2 cycles after the cycle start is sampled, same edge busy falls.
REQ-028 start while busy SHALL be ignored; start in the cycle result_valid rises is accepted only in the following IDLE cycle.
REQ-029 result and overflow SHALL hold unchanged until the next accepted start.
REQ-030 Changing tap_sel, ring_en or open_mode mid-window SHALL not corrupt FSM sequencing; count value then undefined only by the extra/missing edges.

Reset
REQ-031 rst_n low: FSM IDLE, busy 0, result_valid 0, result 0, overflow 0, counters 0, synchroniser flops 0, prescaler 0.
REQ-032 Reset mid-measurement SHALL abort immediately; no result_valid pulse after release.
REQ-033 tap_out not reset-controlled; reflects chain state (0-derived when ring_en = 0 after settling).

Structure
REQ-034 Package ringosc_pkg: FSM state type, tap index function, default parameter constants.
REQ-035 Sub-module ring_chain: parametrised inverter chain with head gating, mode mux and tap mux; measurement FSM stays in top.

Verification
REQ-036 Bench runs open_mode = 1 with chain_in driven by a clk-relative square wave (no zero-delay loop); a closed-ring smoke test uses a delay-annotated inverter model.
REQ-037 chain_in period 16 clk, DIV_BITS 2, GATE_BITS 10, start -> result_valid at cycle 1026 after start, result 16, overflow 0.
REQ-038 chain_in constant 0, start -> result 0, result_valid after GATE_CYCLES+2 cycles.
REQ-039 COUNT_W 3, DIV_BITS 0, chain_in period 4 clk, GATE_BITS 6 -> result 7, overflow 1.
REQ-040 start pulsed again at cycles 5 and 500 of a window -> ignored, single result_valid, busy continuous.
REQ-041 rst_n asserted at cycle 300 of a window -> all outputs 0 at once; after release no result_valid without a new start.
